// File: rtl/loop_stack_ctrl.sv
// Loop-address stack controller: top entry in a register, lower entries in an external RAM
// with a registered read port. A pop that exposes a RAM-held entry spends one REFILL cycle.
module loop_stack_ctrl #(
  parameter int unsigned I_ADDR_WIDTH   = 16,
  parameter int unsigned MAX_LOOP_DEPTH = 32'h100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [I_ADDR_WIDTH-1:0] push_data,
  input  logic                    pop,
  input  logic                    err_clr,
  output logic [I_ADDR_WIDTH-1:0] top_data,
  output logic                    top_valid,
  output logic                    busy,
  output logic [31:0]             depth,
  output logic                    empty,
  output logic                    full,
  output logic                    overflow,
  output logic                    underflow,
  output logic [31:0]             ram_write_addr,
  output logic                    ram_write_en,
  output logic [I_ADDR_WIDTH-1:0] ram_write_data,
  output logic [31:0]             ram_read_addr,
  input  logic [I_ADDR_WIDTH-1:0] ram_read_data
);

  typedef enum logic [0:0] {StIdle, StRefill} state_e;

  state_e                  state_q;
  logic [31:0]             depth_q;
  logic [I_ADDR_WIDTH-1:0] top_q;
  logic                    overflow_q;
  logic                    underflow_q;

  logic is_empty;
  logic is_full;
  logic is_idle;

  assign is_empty = (depth_q == 32'd0);
  assign is_full  = (depth_q == 32'(MAX_LOOP_DEPTH));
  assign is_idle  = (state_q == StIdle);

  assign top_data  = top_q;
  assign top_valid = is_idle && !is_empty;
  assign busy      = (state_q == StRefill);
  assign depth     = depth_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Always addresses the entry just below the top, so a pop can refill on the very next edge.
  assign ram_read_addr = depth_q - 32'd2;

  // The old top spills to RAM in the same cycle a plain push is accepted.
  always_comb begin
    ram_write_en   = 1'b0;
    ram_write_addr = depth_q - 32'd1;
    ram_write_data = top_q;
    if (!rst && is_idle && push && !pop && !is_full && (depth_q >= 32'd1)) begin
      ram_write_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      depth_q     <= 32'd0;
      top_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (err_clr) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      // Error sets come after the clear so a same-cycle error wins.
      unique case (state_q)
        StIdle: begin
          if (push && !pop) begin
            if (is_full) begin
              overflow_q <= 1'b1;
            end else begin
              top_q   <= push_data;
              depth_q <= depth_q + 32'd1;
            end
          end else if (pop) begin
            if (is_empty) begin
              underflow_q <= 1'b1;
            end else if (push) begin
              top_q <= push_data;
            end else begin
              depth_q <= depth_q - 32'd1;
              if (depth_q >= 32'd2) begin
                state_q <= StRefill;
              end
            end
          end
        end
        StRefill: begin
          top_q   <= ram_read_data;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/loop_stack_ctrl.md
LOOP_STACK_CTRL -- requirements
Module: loop_stack_ctrl

Interface
REQ-001 SHALL have parameter I_ADDR_WIDTH, default 8'd16: width of a stacked instruction address.
REQ-002 SHALL have parameter MAX_LOOP_DEPTH, default 32'h100: stack capacity in entries.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 push  input  1  push push_data (loop entry '[').
REQ-006 push_data  input  I_ADDR_WIDTH  instruction address to stack.
REQ-007 pop  input  1  discard top entry (loop exit).
REQ-008 err_clr  input  1  synchronous clear of overflow/underflow flags.
REQ-009 top_data  output  I_ADDR_WIDTH  current top-of-stack value.
REQ-010 top_valid  output  1  high when depth>0 and state IDLE.
REQ-011 busy  output  1  high in state REFILL; commands ignored.
REQ-012 depth  output  32  number of stacked entries.
REQ-013 empty / full  output  1 each  depth==0 / depth==MAX_LOOP_DEPTH.
REQ-014 overflow / underflow  output  1 each  sticky error flags.
REQ-015 ram_write_addr  output  32  to stack RAM write port.
REQ-016 ram_write_en  output  1  to stack RAM write enable.
REQ-017 ram_write_data  output  I_ADDR_WIDTH  to stack RAM write data.
REQ-018 ram_read_addr  output  32  to stack RAM read address.
REQ-019 ram_read_data  input  I_ADDR_WIDTH  from stack RAM; registered, valid one cycle after address sampled.

Function
REQ-020 Storage model SHALL be: entry depth-1 held in internal register top_reg; entries 0..depth-2 held in RAM at address equal to index.
REQ-021 top_data SHALL equal top_reg combinationally; value meaningless when top_valid=0.
REQ-022 FSM SHALL have two states: IDLE (accept commands) and REFILL (load new top from RAM).
REQ-023 ram_read_addr SHALL equal depth-2 (32-bit modulo) at all times, combinationally from the depth register only.
REQ-024 IDLE, push=1 pop=0, not full: top_reg<=push_data, depth<=depth+1; if depth>=1, ram_write_en=1 same cycle with addr depth-1, data top_reg.
REQ-025 IDLE, push=0 pop=1, not empty: depth<=depth-1; if depth>=2 go REFILL, else stay IDLE.
REQ-026 REFILL: top_reg<=ram_read_data, return to IDLE after exactly one cycle; busy=1, top_valid=0 during it.
REQ-027 IDLE, push=1 pop=1, not empty: replace top (top_reg<=push_data), depth unchanged, no RAM write; permitted when full.
REQ-028 push (alone) when full: no state change, no RAM write, overflow<=1.
REQ-029 pop or push+pop when empty: no state change, underflow<=1.
REQ-030 push/pop during REFILL SHALL be ignored with no flag change.
REQ-031 ram_write_en SHALL be 0 in every case not covered by REQ-024 and whenever rst=1.
REQ-032 err_clr SHALL clear both flags; a same-cycle new error SHALL win (flag set).
REQ-033 Push-then-pop back-to-back SHALL return the correct previous top (RAM write precedes read by one edge; no bypass needed).

Reset
REQ-034 rst=1 SHALL immediately force state IDLE, depth=0, top_reg=0, overflow=0, underflow=0; hence empty=1, full=0, top_valid=0, busy=0, ram_write_en=0.
REQ-035 rst asserted in REFILL SHALL abandon the refill; no RAM content is relied on after reset.

Verification
REQ-036 Reset, push 0x0010, 0x0020, 0x0030 -> depth 3, top_data 0x0030, RAM[0]=0x0010, RAM[1]=0x0020, two RAM writes seen.
REQ-037 From REQ-036 state, pop -> next cycle busy=1, top_valid=0; following cycle top_data=0x0020, depth 2; pop again -> top 0x0010, depth 1; pop -> empty=1, no REFILL cycle.
REQ-038 Pop on empty -> underflow=1, depth 0; err_clr -> underflow=0; err_clr with simultaneous pop on empty -> underflow stays 1.
REQ-039 Fill to 256 entries (MAX_LOOP_DEPTH=0x100), push again -> overflow=1, depth 256, full=1; push+pop at full -> top replaced, depth 256, no RAM write.
REQ-040 Push 0x1111 then pop next cycle then push 0x2222 during busy -> busy push ignored, top 0x1111's predecessor restored, depth unchanged by ignored push.
REQ-041 Assert rst mid-REFILL -> outputs per REQ-034 immediately; subsequent push 0x0042 -> depth 1, top 0x0042, no RAM write.
